// File: rtl/fancy_timer_ctrl.sv
// fancy_timer_ctrl: watches a serial stream for the pattern 1101. It then loads a
// 4-bit delay MSB-first and runs a countdown of (delay+1)*TICK_CYCLES cycles. It
// holds done until the user acknowledges the expiry.
// Optional feature macro: TIMER_ABORT_EN adds the abort input, which cancels
// any activity and returns the block to SEARCH.
// Handshake: done rises when the countdown expires and stays high until ack is
// sampled high in WAIT_ACK. ack is ignored in every other state.
module fancy_timer_ctrl #(
    parameter int TICK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data,
    input  logic       ack,
`ifdef TIMER_ABORT_EN
    input  logic       abort,
`endif
    output logic [3:0] count,
    output logic       counting,
    output logic       done,
    output logic [3:0] dbg_state
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [3:0] {
        SEARCH   = 4'd0,
        S1       = 4'd1,
        S11      = 4'd2,
        S110     = 4'd3,
        LOAD0    = 4'd4,
        LOAD1    = 4'd5,
        LOAD2    = 4'd6,
        LOAD3    = 4'd7,
        COUNT    = 4'd8,
        WAIT_ACK = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      delay_q, delay_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            abort_req;

`ifdef TIMER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State, delay and tick registers; reset lands everything in an idle SEARCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            delay_q <= 4'd0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic: pattern search, delay load, countdown and ack wait.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        tick_d  = tick_q;
        case (state_q)
            SEARCH:   state_d = data ? S1 : SEARCH;
            S1:       state_d = data ? S11 : SEARCH;
            S11:      state_d = data ? S11 : S110;
            S110:     state_d = data ? LOAD0 : SEARCH;
            LOAD0: begin
                delay_d = {delay_q[2:0], data};
                state_d = LOAD1;
            end
            LOAD1: begin
                delay_d = {delay_q[2:0], data};
                state_d = LOAD2;
            end
            LOAD2: begin
                delay_d = {delay_q[2:0], data};
                state_d = LOAD3;
            end
            LOAD3: begin
                delay_d = {delay_q[2:0], data};
                tick_d  = '0;
                state_d = COUNT;
            end
            COUNT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    // The step ending at zero expires the timer instead of underflowing.
                    if (delay_q != 4'd0) begin
                        delay_d = delay_q - 4'd1;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
                delay_d = 4'd0;
                tick_d  = '0;
            end
        endcase
        // Abort overrides everything, including a simultaneous ack.
        if (abort_req && state_q != SEARCH) begin
            state_d = SEARCH;
            delay_d = 4'd0;
            tick_d  = '0;
        end
    end

    assign count     = delay_q;
    assign counting  = (state_q == COUNT);
    assign done      = (state_q == WAIT_ACK);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fancy_timer_ctrl.sv
// Directed testbench for fancy_timer_ctrl with TICK_CYCLES=5.
module tb_fancy_timer_ctrl;

    localparam int T = 5;

    // Clock and reset
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data = 1'b0;
    logic       ack = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] count;
    logic       counting;
    logic       done;
    logic [3:0] dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fancy_timer_ctrl #(.TICK_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .ack       (ack),
`ifdef TIMER_ABORT_EN
        .abort     (abort),
`endif
        .count     (count),
        .counting  (counting),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // One clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int c, input bit cn, input bit dn);
        check({tag, ".count"}, 8'(count), 8'(c));
        check({tag, ".counting"}, 8'(counting), 8'(cn));
        check({tag, ".done"}, 8'(done), 8'(dn));
    endtask

    // Drive four bits MSB-first, one per clock.
    task automatic send4(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) begin
            data = bits[i];
            step();
        end
        data = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check_outs("reset", 0, 0, 0);
        check("reset.state", 8'(dbg_state), 8'd0);
        step();
        reset = 1'b0;

        // Delay 5: counting 30 cycles, count 5..0 in 5-cycle steps
        send4(4'b1101);
        check("t1.load0", 8'(dbg_state), 8'd4);
        send4(4'b0101);
        for (int i = 0; i < 6 * T; i++) begin
            check_outs("t1.run", 5 - i / T, 1, 0);
            step();
        end
        check_outs("t1.expired", 0, 0, 1);
        step();
        step();
        check_outs("t1.hold", 0, 0, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_outs("t1.acked", 0, 0, 0);
        check("t1.search", 8'(dbg_state), 8'd0);

        // Overlapping pattern 11101, delay 0: counting exactly 5 cycles
        data = 1'b1;
        step();
        send4(4'b1101);
        check("t2.load0", 8'(dbg_state), 8'd4);
        send4(4'b0000);
        for (int i = 0; i < T; i++) begin
            check_outs("t2.run", 0, 1, 0);
            step();
        end
        check_outs("t2.expired", 0, 0, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t2.search", 8'(dbg_state), 8'd0);

        // Delay 15: 80 cycles, with 1101 injected on data during the count
        send4(4'b1101);
        send4(4'b1111);
        for (int i = 0; i < 16 * T; i++) begin
            check_outs("t3.run", 15 - i / T, 1, 0);
            data = (i % 4 == 2) ? 1'b0 : 1'b1;
            step();
        end
        data = 1'b0;
        check_outs("t3.expired", 0, 0, 1);
        ack = 1'b1;
        step();
        check("t3.search", 8'(dbg_state), 8'd0);

        // ack held high throughout: done lasts one cycle, then new pattern found
        send4(4'b1101);
        send4(4'b0001);
        for (int i = 0; i < 2 * T; i++) begin
            check_outs("t4.run", 1 - i / T, 1, 0);
            step();
        end
        check_outs("t4.done_pulse", 0, 0, 1);
        step();
        check_outs("t4.after_pulse", 0, 0, 0);
        check("t4.search", 8'(dbg_state), 8'd0);
        send4(4'b1101);
        check("t4.load0", 8'(dbg_state), 8'd4);
        ack = 1'b0;

        // Async reset mid-count at count=3
        send4(4'b0101);
        for (int i = 0; i < 2 * T; i++) step();
        check_outs("t5.pre_reset", 3, 1, 0);
        #1 reset = 1'b1;
        #1;
        check_outs("t5.in_reset", 0, 0, 0);
        check("t5.state", 8'(dbg_state), 8'd0);
        #1 reset = 1'b0;
        data = 1'b1;
        step();
        check("t5.first_bit", 8'(dbg_state), 8'd1);
        step();
        data = 1'b0;
        step();
        data = 1'b1;
        step();
        data = 1'b0;
        check("t5.load0", 8'(dbg_state), 8'd4);

`ifdef TIMER_ABORT_EN
        // Abort in LOAD2, then abort with ack in WAIT_ACK
        step();
        step();
        check("t6.load2", 8'(dbg_state), 8'd6);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("t6.abort_load", 0, 0, 0);
        check("t6.abort_load.state", 8'(dbg_state), 8'd0);
        send4(4'b1101);
        send4(4'b0000);
        for (int i = 0; i < T; i++) step();
        check_outs("t6.wait", 0, 0, 1);
        abort = 1'b1;
        ack = 1'b1;
        step();
        abort = 1'b0;
        ack = 1'b0;
        check_outs("t6.abort_wait", 0, 0, 0);
        check("t6.abort_wait.state", 8'(dbg_state), 8'd0);
`else
        // Finish the load of zero, run out, acknowledge
        for (int i = 0; i < 4; i++) step();
        check_outs("t6.run", 0, 1, 0);
        for (int i = 0; i < T; i++) step();
        check_outs("t6.wait", 0, 0, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t6.search", 8'(dbg_state), 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
